psram_seq_ctrl: RTL and testbench

// - Parametrised PSRAM transaction sequencer, successor to the fixed octal core: runtime x1/x4/x8 bus mode, programmable clk_i:sck ratio.
// - Accepts single read/write requests of 1..4 bytes from the bus-side bridge and runs CE#/SCK/IO to the device.
// - Phases: command -> address -> wait -> data. One transaction in flight; no bursts beyond one word.

---
 rtl/psram_seq_ctrl_if.sv | 29 ++
 rtl/psram_seq_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_psram_seq_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_seq_ctrl_if.sv
// Bus-side request/response and configuration bundle for the PSRAM sequencer.
interface psram_seq_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 24
);
  logic [1:0]            cfg_mode;
  logic [7:0]            cfg_rd_cmd;
  logic [7:0]            cfg_wr_cmd;
  logic [4:0]            cfg_rd_wait;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_len;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;

  modport master (
    output cfg_mode, cfg_rd_cmd, cfg_wr_cmd, cfg_rd_wait,
    output req_valid, req_we, req_addr, req_len, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cfg_mode, cfg_rd_cmd, cfg_wr_cmd, cfg_rd_wait,
    input  req_valid, req_we, req_addr, req_len, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/psram_seq_ctrl.sv
// PSRAM transaction sequencer: single 1..4 byte read/write, x1/x4/x8 bus,
// command -> address -> wait -> data, SDR sampling, programmable sck ratio.
module psram_seq_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned CE_HOLD    = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  psram_seq_ctrl_if.slave bus,
  output logic            psram_sck_o,
  output logic            psram_ce_o,
  output logic [7:0]      psram_io_en_o,
  input  logic [7:0]      psram_io_in_i,
  output logic [7:0]      psram_io_out_o,
  output logic            psram_dqs_en_o,
  input  logic            psram_dqs_in_i,
  output logic            psram_dqs_out_o
);

  localparam int unsigned HALF   = CLK_DIV / 2;
  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned HOLD_W = $clog2(CE_HOLD + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(HALF - 1);

  localparam logic [1:0] MODE_SPI = 2'd0;
  localparam logic [1:0] MODE_QPI = 2'd1;
  localparam logic [1:0] MODE_OPI = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_WAIT, ST_DATA, ST_DONE
  } state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [4:0]            bit_cnt;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [31:0]           tx_sh;
  logic [31:0]           rx_sh;
  logic [1:0]            mode_q;
  logic                  we_q;
  logic [1:0]            len_q;
  logic [4:0]            wait_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic [1:0]  mode_in;
  logic [7:0]  cmd_in;
  logic [31:0] tx_nxt;
  logic [31:0] rx_next;
  logic [31:0] tx_data;
  logic [31:0] tx_addr;
  logic        unused_inputs;

  // Shift the transmit word by one sck worth of bits.
  function automatic logic [31:0] shift_out(input logic [31:0] s, input logic [1:0] m);
    case (m)
      MODE_QPI: return {s[27:0], 4'b0};
      MODE_OPI: return {s[23:0], 8'b0};
      default:  return {s[30:0], 1'b0};
    endcase
  endfunction

  // Pad values for the current sck period, taken from the top of the word.
  function automatic logic [7:0] lane_out(input logic [31:0] s, input logic [1:0] m);
    case (m)
      MODE_QPI: return {4'b0, s[31:28]};
      MODE_OPI: return s[31:24];
      default:  return {7'b0, s[31]};
    endcase
  endfunction

  // Pins driven while the controller owns the bus.
  function automatic logic [7:0] lane_en(input logic [1:0] m);
    case (m)
      MODE_QPI: return 8'h0F;
      MODE_OPI: return 8'hFF;
      default:  return 8'h01;
    endcase
  endfunction

  // Append one sck worth of received bits; SPI reads arrive on io[1].
  function automatic logic [31:0] shift_in(input logic [31:0] r, input logic [1:0] m,
                                           input logic [7:0] io);
    case (m)
      MODE_QPI: return {r[27:0], io[3:0]};
      MODE_OPI: return {r[23:0], io};
      default:  return {r[30:0], io[1]};
    endcase
  endfunction

  // Phase lengths in sck periods, minus one.
  function automatic logic [4:0] cmd_last(input logic [1:0] m);
    case (m)
      MODE_QPI: return 5'd1;
      MODE_OPI: return 5'd0;
      default:  return 5'd7;
    endcase
  endfunction

  function automatic logic [4:0] addr_last(input logic [1:0] m);
    case (m)
      MODE_QPI: return 5'(ADDR_WIDTH / 4 - 1);
      MODE_OPI: return 5'(ADDR_WIDTH / 8 - 1);
      default:  return 5'(ADDR_WIDTH - 1);
    endcase
  endfunction

  function automatic logic [4:0] data_last(input logic [1:0] m, input logic [1:0] len);
    case (m)
      MODE_QPI: return {2'b0, len, 1'b1};
      MODE_OPI: return {3'b0, len};
      default:  return {len, 3'b111};
    endcase
  endfunction

  function automatic logic [31:0] byte_rev(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Request-side decode and datapath helpers.
  assign mode_in       = (bus.cfg_mode == 2'd3) ? MODE_SPI : bus.cfg_mode;
  assign cmd_in        = bus.req_we ? bus.cfg_wr_cmd : bus.cfg_rd_cmd;
  assign tx_nxt        = shift_out(tx_sh, mode_q);
  assign rx_next       = shift_in(rx_sh, mode_q, psram_io_in_i);
  assign tx_data       = we_q ? byte_rev(wdata_q) : 32'h0;
  assign tx_addr       = {addr_q, {(32 - ADDR_WIDTH){1'b0}}};
  assign psram_dqs_out_o = 1'b0;
  assign unused_inputs = psram_dqs_in_i;

  // Sequencer: phase FSM, sck divider, shift registers and registered pads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= ST_IDLE;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      hold_cnt       <= '0;
      tx_sh          <= '0;
      rx_sh          <= '0;
      mode_q         <= MODE_SPI;
      we_q           <= 1'b0;
      len_q          <= '0;
      wait_q         <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      psram_sck_o    <= 1'b0;
      psram_ce_o     <= 1'b1;
      psram_io_en_o  <= '0;
      psram_io_out_o <= '0;
      psram_dqs_en_o <= 1'b0;
      bus.req_ready  <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
    end else begin
      bus.rsp_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          if (bus.req_valid && bus.req_ready) begin
            bus.req_ready  <= 1'b0;
            mode_q         <= mode_in;
            we_q           <= bus.req_we;
            len_q          <= bus.req_len;
            wait_q         <= bus.cfg_rd_wait;
            addr_q         <= bus.req_addr;
            wdata_q        <= bus.req_wdata;
            tx_sh          <= {cmd_in, 24'h0};
            rx_sh          <= '0;
            psram_io_out_o <= lane_out({cmd_in, 24'h0}, mode_in);
            psram_io_en_o  <= lane_en(mode_in);
            psram_ce_o     <= 1'b0;
            psram_sck_o    <= 1'b0;
            div_cnt        <= '0;
            bit_cnt        <= cmd_last(mode_in);
            state          <= ST_CMD;
          end else begin
            bus.req_ready <= (hold_cnt <= HOLD_W'(1));
          end
        end

        ST_CMD, ST_ADDR, ST_WAIT, ST_DATA: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt     <= '0;
            psram_sck_o <= 1'b0;
            if (state == ST_DATA && !we_q) rx_sh <= rx_next;
            if (bit_cnt != '0) begin
              bit_cnt        <= bit_cnt - 1'b1;
              tx_sh          <= tx_nxt;
              psram_io_out_o <= lane_out(tx_nxt, mode_q);
            end else if (state == ST_CMD) begin
              tx_sh          <= tx_addr;
              psram_io_out_o <= lane_out(tx_addr, mode_q);
              bit_cnt        <= addr_last(mode_q);
              state          <= ST_ADDR;
            end else if (state == ST_ADDR && !we_q && wait_q != '0) begin
              // Dummy cycles: release the bus so the device can turn it around.
              tx_sh          <= '0;
              psram_io_out_o <= '0;
              psram_io_en_o  <= '0;
              bit_cnt        <= wait_q - 1'b1;
              state          <= ST_WAIT;
            end else if (state != ST_DATA) begin
              tx_sh          <= tx_data;
              psram_io_out_o <= lane_out(tx_data, mode_q);
              psram_io_en_o  <= we_q ? lane_en(mode_q) : 8'h00;
              psram_dqs_en_o <= we_q && (mode_q == MODE_OPI);
              bit_cnt        <= data_last(mode_q, len_q);
              state          <= ST_DATA;
            end else begin
              // Last data period done: close the transaction and report.
              psram_ce_o     <= 1'b1;
              psram_io_en_o  <= '0;
              psram_io_out_o <= '0;
              psram_dqs_en_o <= 1'b0;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_rdata  <= we_q ? 32'h0 : byte_rev(rx_next << {~len_q, 3'b000});
              hold_cnt       <= HOLD_W'(CE_HOLD - 1);
              state          <= ST_DONE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == DIV_RISE) psram_sck_o <= 1'b1;
          end
        end

        ST_DONE: begin
          // DONE is the first CE-high cycle of the inter-transaction gap.
          if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
          bus.req_ready <= (hold_cnt <= HOLD_W'(1));
          state         <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_seq_ctrl.sv
// Directed bench for psram_seq_ctrl with a small PSRAM pin model.
module tb_psram_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  psram_seq_ctrl_if bus ();
  psram_seq_ctrl_if bus8 ();

  logic       sck, ce, dqs_en, dqs_out;
  logic [7:0] io_en, io_in, io_out;
  logic       sck8, ce8, dqs_en8, dqs_out8;
  logic [7:0] io_en8, io_in8, io_out8;

  psram_seq_ctrl #(.CLK_DIV(4), .ADDR_WIDTH(24), .CE_HOLD(2)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus.slave),
    .psram_sck_o(sck), .psram_ce_o(ce), .psram_io_en_o(io_en),
    .psram_io_in_i(io_in), .psram_io_out_o(io_out),
    .psram_dqs_en_o(dqs_en), .psram_dqs_in_i(1'b0), .psram_dqs_out_o(dqs_out)
  );

  psram_seq_ctrl #(.CLK_DIV(8), .ADDR_WIDTH(24), .CE_HOLD(2)) u_dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus8.slave),
    .psram_sck_o(sck8), .psram_ce_o(ce8), .psram_io_en_o(io_en8),
    .psram_io_in_i(io_in8), .psram_io_out_o(io_out8),
    .psram_dqs_en_o(dqs_en8), .psram_dqs_in_i(1'b0), .psram_dqs_out_o(dqs_out8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] lane_mask(input int w);
    return (w == 1) ? 8'h01 : (w == 4) ? 8'h0F : 8'hFF;
  endfunction

  // Pin model: captures io_out per sck period, returns m_rsp from m_dstart on.
  int           m_w      = 1;
  int           m_dstart = 1000;
  logic [31:0]  m_rsp    = '0;
  int           sck_n    = 0;
  logic [127:0] cap      = '0;
  logic [7:0]   en_or    = '0;
  logic [7:0]   late_en_or = '0;
  logic         dqs_or   = 1'b0;
  int           sck_hi_n = 0;
  logic [31:0]  m_stream;
  logic [7:0]   m_chunk;
  int           both_cnt = 0;
  int           rsp_cnt  = 0;
  int           ce8_lo_n = 0;
  int           sck8_hi_n = 0;
  logic [7:0]   en8_or   = '0;

  always @(negedge ce) begin
    sck_n = 0; cap = '0; en_or = '0; late_en_or = '0; dqs_or = 1'b0; sck_hi_n = 0; io_in = '0;
  end

  always @(posedge sck) begin
    if (!ce) begin
      cap = (cap << m_w) | 128'(io_out & lane_mask(m_w));
      if (sck_n >= 8 / m_w + 24 / m_w) late_en_or = late_en_or | io_en;
      if (sck_n >= m_dstart) begin
        m_stream = {m_rsp[7:0], m_rsp[15:8], m_rsp[23:16], m_rsp[31:24]};
        m_stream = m_stream << ((sck_n - m_dstart) * m_w);
        m_chunk  = m_stream[31:24] >> (8 - m_w);
        io_in    = (m_w == 1) ? {6'b0, m_chunk[0], 1'b0} : m_chunk;
      end
      sck_n++;
    end
  end

  always @(negedge clk) begin
    if (!ce) begin
      en_or  = en_or | io_en;
      dqs_or = dqs_or | dqs_en;
      if (sck) sck_hi_n++;
    end
    if (bus.rsp_valid && bus.req_ready) both_cnt++;
    if (bus.rsp_valid) rsp_cnt++;
    if (!ce8) begin
      ce8_lo_n++;
      en8_or = en8_or | io_en8;
      if (sck8) sck8_hi_n++;
    end
  end

  // Issue one request on the main DUT; lat counts clk cycles from accept to rsp_valid.
  task automatic run_req(input logic we, input logic [23:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, output int lat);
    int guard;
    @(negedge clk);
    bus.req_we = we; bus.req_addr = addr; bus.req_len = len; bus.req_wdata = wdata;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin @(negedge clk); guard++; end
    lat = 1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
  endtask

  int lat, hi, guard, rsp_before;
  logic [127:0] cap1;

  initial begin
    rst_n = 1'b0;
    bus.cfg_mode = 2'd0; bus.cfg_rd_cmd = 8'h03; bus.cfg_wr_cmd = 8'h02; bus.cfg_rd_wait = 5'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_len = '0; bus.req_wdata = '0;
    bus8.cfg_mode = 2'd3; bus8.cfg_rd_cmd = 8'h03; bus8.cfg_wr_cmd = 8'h02; bus8.cfg_rd_wait = 5'd0;
    bus8.req_valid = 1'b0; bus8.req_we = 1'b0; bus8.req_addr = '0; bus8.req_len = '0; bus8.req_wdata = '0;
    io_in = '0; io_in8 = 8'h02;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_ce", ce, 1);
    check("rst_sck", sck, 0);
    check("rst_io_en_out", {io_en, io_out}, 0);
    check("rst_dqs", {dqs_en, dqs_out}, 0);
    check("rst_ready_rsp", {bus.req_ready, bus.rsp_valid}, 0);
    check("rst_rdata", bus.rsp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1);

    // SPI read 1 byte, no dummy cycles.
    m_w = 1; m_dstart = 32; m_rsp = 32'h777777A5;
    run_req(1'b0, 24'h123456, 2'd0, 32'h0, lat);
    check("spi_rd_latency", lat, 161);
    check("spi_rd_rdata", bus.rsp_rdata, 32'h000000A5);
    check("spi_rd_cmd_addr", cap[39:8], 32'h03123456);
    check("spi_rd_sck_cnt", sck_n, 40);
    check("spi_rd_sck_hi", sck_hi_n, 80);
    check("spi_rd_io_en", en_or, 8'h01);
    check("spi_rd_rsp_ce", {bus.rsp_valid, ce, sck}, 3'b110);

    // QPI write 4 bytes.
    bus.cfg_mode = 2'd1; bus.cfg_wr_cmd = 8'h38;
    m_w = 4; m_dstart = 1000;
    run_req(1'b1, 24'h000010, 2'd3, 32'hDEADBEEF, lat);
    check("qpi_wr_latency", lat, 65);
    check("qpi_wr_stream", cap[63:0], 64'h38000010EFBEADDE);
    check("qpi_wr_sck_cnt", sck_n, 16);
    check("qpi_wr_io_en", en_or, 8'h0F);
    check("qpi_wr_rdata", bus.rsp_rdata, 0);
    check("qpi_wr_dqs", dqs_or, 0);

    // OPI read 2 bytes with 6 dummy cycles.
    bus.cfg_mode = 2'd2; bus.cfg_rd_cmd = 8'hEB; bus.cfg_rd_wait = 5'd6;
    m_w = 8; m_dstart = 10; m_rsp = 32'hCCBB1234;
    run_req(1'b0, 24'hABCDEF, 2'd1, 32'h0, lat);
    check("opi_rd_latency", lat, 49);
    check("opi_rd_cmd_addr", cap[95:64], 32'hEBABCDEF);
    check("opi_rd_wait_data_out", cap[63:0], 0);
    check("opi_rd_sck_cnt", sck_n, 12);
    check("opi_rd_late_io_en", late_en_or, 0);
    check("opi_rd_dqs", dqs_or, 0);
    check("opi_rd_rdata", bus.rsp_rdata, 32'h00001234);

    // OPI write 2 bytes: data mask enabled.
    m_dstart = 1000;
    run_req(1'b1, 24'h00ABCD, 2'd1, 32'h00005AC3, lat);
    check("opi_wr_latency", lat, 25);
    check("opi_wr_stream", cap[47:0], 48'h3800ABCDC35A);
    check("opi_wr_io_en", en_or, 8'hFF);
    check("opi_wr_dqs", {dqs_or, dqs_out}, 2'b10);

    // Back-to-back SPI writes with req_valid held; cfg changed mid-transaction.
    bus.cfg_mode = 2'd0; bus.cfg_wr_cmd = 8'h02; bus.cfg_rd_wait = 5'd0;
    m_w = 1; m_dstart = 1000;
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_addr = 24'h0000F0; bus.req_len = 2'd0; bus.req_wdata = 32'h5A;
    bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.cfg_wr_cmd = 8'h99;
    guard = 0;
    while (!bus.rsp_valid && guard < 3000) begin @(negedge clk); guard++; end
    cap1 = cap;
    hi = 0;
    while (ce && hi < 20) begin hi++; @(negedge clk); end
    bus.req_valid = 1'b0;
    check("b2b_ce_high", hi, 2);
    check("b2b_first_stream", cap1[39:0], 40'h020000F05A);
    lat = 1;
    while (!bus.rsp_valid && lat < 3000) begin @(negedge clk); lat++; end
    check("b2b_second_latency", lat, 161);
    check("b2b_second_cmd", cap[39:32], 8'h99);

    // CLK_DIV=8 build, mode 3 decoded as SPI.
    ce8_lo_n = 0; sck8_hi_n = 0; en8_or = '0;
    @(negedge clk);
    bus8.req_we = 1'b0; bus8.req_addr = 24'h000001; bus8.req_len = 2'd0; bus8.req_valid = 1'b1;
    guard = 0;
    while (!bus8.req_ready && guard < 100) begin @(negedge clk); guard++; end
    lat = 1;
    @(negedge clk);
    bus8.req_valid = 1'b0;
    while (!bus8.rsp_valid && lat < 5000) begin @(negedge clk); lat++; end
    check("div8_latency", lat, 321);
    check("div8_rdata", bus8.rsp_rdata, 32'h000000FF);
    check("div8_ce_low_cycles", ce8_lo_n, 320);
    check("div8_sck_hi_cycles", sck8_hi_n, 160);
    check("div8_mode3_io_en", en8_or, 8'h01);
    @(negedge clk);
    check("div8_idle_pins", {ce8, sck8}, 2'b10);

    // Reset in the middle of the SPI address phase.
    bus.cfg_mode = 2'd0; bus.cfg_rd_cmd = 8'h03;
    m_w = 1; m_dstart = 32;
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_addr = 24'h654321; bus.req_len = 2'd0; bus.req_valid = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    guard = 0;
    while (sck_n < 12 && guard < 500) begin @(negedge clk); guard++; end
    check("mid_addr_reached", io_en, 8'h01);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ce", ce, 1);
    check("mid_rst_io_en", io_en, 0);
    check("mid_rst_sck", sck, 0);
    rsp_before = rsp_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_rst_no_rsp", rsp_cnt, rsp_before);
    check("mid_rst_ready", bus.req_ready, 1);

    check("rsp_ready_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
